// File: rtl/ls_pkg.sv
// Shared definitions for the load/store memory-access stage.
// Holds the decode mask encodings, the size field values, the response error
// codes, the access FSM state type and the alignment check helper.
package ls_pkg;

  // Decode mask: bit 2 = signed, bits 1:0 = size
  localparam logic [2:0] MASK_LW   = 3'b110;
  localparam logic [2:0] MASK_LB   = 3'b100;
  localparam logic [2:0] MASK_LBU  = 3'b000;
  localparam logic [2:0] MASK_LH   = 3'b101;
  localparam logic [2:0] MASK_LHU  = 3'b001;
  localparam logic [2:0] MASK_NONE = 3'b111;

  localparam logic [1:0] SIZE_B    = 2'b00;
  localparam logic [1:0] SIZE_H    = 2'b01;
  localparam logic [1:0] SIZE_W    = 2'b10;
  localparam logic [1:0] SIZE_NONE = 2'b11;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  // LATCH sits between the ack and the response so the returned RAM word is
  // registered before lane extraction/extension.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_LATCH,
    ST_RESP,
    ST_FAULT
  } lsu_state_e;

  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] lo);
    case (size)
      SIZE_H:  return lo[0];
      SIZE_W:  return |lo;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane alignment for word-wide RAM accesses.
//   mask      : decode mask (bit 2 signed, bits 1:0 size)
//   addr_lo   : byte offset within the word
//   wdata     : right-aligned store data
//   rdata     : raw RAM read word
//   be        : byte enables for the access
//   wdata_rep : store data replicated across all lanes of its size
//   rdata_ext : selected lane, sign/zero extended (word passes through)
module lsu_lane_align
  import ls_pkg::*;
(
  input  logic [2:0]  mask,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        sgn;

  always_comb begin
    lane_b    = 8'(rdata >> {addr_lo, 3'b000});
    lane_h    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    sgn       = mask[2];
    be        = '0;
    wdata_rep = wdata;
    rdata_ext = rdata;
    case (mask[1:0])
      SIZE_B: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{sgn & lane_b[7]}}, lane_b};
      end
      SIZE_H: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{sgn & lane_h[15]}}, lane_h};
      end
      SIZE_W: begin
        be = '1;
      end
      default: begin
        be        = '0;
        rdata_ext = '0;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_access.sv
// Load/store memory-access stage.
// Accepts one decoded load/store at a time, performs a single handshaked
// word access on the data RAM and returns one response pulse per accepted
// request (extended load data, or an error code).
//   clk, rst_n            : clock, synchronous active-low reset
//   req_valid/req_ready   : request handshake (stall while valid & !ready)
//   memread/memwrite/is_ls/mask/addr/wdata : decoded request
//   ram_req/ram_we/ram_addr/ram_be/ram_wdata : RAM request (held until ack)
//   ram_ack/ram_rdata     : RAM completion and read data
//   resp_valid/resp_rdata/resp_err : one-cycle response
module lsu_mem_access
  import ls_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              memread,
  input  logic              memwrite,
  input  logic              is_ls,
  input  logic [2:0]        mask,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-3:0] ram_addr,
  output logic [3:0]        ram_be,
  output logic [31:0]       ram_wdata,
  input  logic              ram_ack,
  input  logic [31:0]       ram_rdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic [1:0]        resp_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic [2:0]        mask_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;

  logic [3:0]        be;
  logic [31:0]       wdata_rep;
  logic [31:0]       rdata_ext;

  logic              accept;
  logic              pass_thru;

  // One aligner serves both directions: all of its inputs come from the
  // registered request, so the RAM-side fields and the load extension never
  // overlap in time.
  lsu_lane_align u_align (
    .mask      (mask_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (rdata_q),
    .be        (be),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext)
  );

  always_comb begin
    accept    = req_valid && req_ready;
    pass_thru = !is_ls || (mask[1:0] == SIZE_NONE);
    ram_we    = ram_req & we_q;
    ram_addr  = ram_req ? addr_q[ADDR_W-1:2] : '0;
    ram_be    = ram_req ? be : '0;
    ram_wdata = ram_req ? wdata_rep : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      ram_req    <= 1'b0;
      we_q       <= 1'b0;
      mask_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= ERR_OK;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= ERR_OK;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (pass_thru) begin
              resp_valid <= 1'b1;
            end else if (is_misaligned(mask[1:0], addr[1:0])) begin
              state      <= ST_FAULT;
              req_ready  <= 1'b0;
              resp_valid <= 1'b1;
              resp_err   <= ERR_MISALIGN;
            end else begin
              state     <= ST_ACCESS;
              req_ready <= 1'b0;
              ram_req   <= 1'b1;
              // memread & memwrite together resolves to a store
              we_q      <= memwrite;
              mask_q    <= mask;
              addr_q    <= addr;
              wdata_q   <= wdata;
              cnt       <= '0;
            end
          end
        end
        ST_ACCESS: begin
          // Ack is checked first so an ack on the expiry cycle still succeeds
          if (ram_ack) begin
            ram_req <= 1'b0;
            rdata_q <= ram_rdata;
            state   <= ST_LATCH;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            ram_req    <= 1'b0;
            state      <= ST_FAULT;
            resp_valid <= 1'b1;
            resp_err   <= ERR_TIMEOUT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_LATCH: begin
          state      <= ST_RESP;
          resp_valid <= 1'b1;
          resp_rdata <= we_q ? '0 : rdata_ext;
        end
        ST_RESP, ST_FAULT: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          ram_req   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && accept && is_ls) begin
      assert (!(memread && memwrite));
    end
  end

endmodule

// File: tb/tb_lsu_mem_access.sv
module tb_lsu_mem_access;
  import ls_pkg::*;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned TMO    = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              memread;
  logic              memwrite;
  logic              is_ls;
  logic [2:0]        mask;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-3:0] ram_addr;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic              ram_ack;
  logic [31:0]       ram_rdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic [1:0]        resp_err;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  lsu_mem_access #(.ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .memread    (memread),
    .memwrite   (memwrite),
    .is_ls      (is_ls),
    .mask       (mask),
    .addr       (addr),
    .wdata      (wdata),
    .ram_req    (ram_req),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_be     (ram_be),
    .ram_wdata  (ram_wdata),
    .ram_ack    (ram_ack),
    .ram_rdata  (ram_rdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] m, input logic [1:0] lo,
                                             input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    if (m[1:0] == 2'b00) return m[2] ? {{24{b[7]}}, b} : {24'h0, b};
    if (m[1:0] == 2'b01) return m[2] ? {{16{h[15]}}, h} : {16'h0, h};
    return w;
  endfunction

  // One complete request: drive, serve the RAM side (ack on the ack_cyc-th
  // cycle of ram_req, 0 = never), then compare the response with the
  // scoreboard entry pushed at drive time.
  task automatic xact(input string tag, input logic ls, input logic rd, input logic wr,
                      input logic [2:0] m, input logic [31:0] a, input logic [31:0] wd,
                      input int ack_cyc, input logic [31:0] word,
                      input logic [3:0] want_be, input logic [31:0] want_wd,
                      input logic [31:0] want_rd, input logic [1:0] want_err,
                      input int want_reqs, input int want_lat);
    exp_t e;
    int   cyc;
    int   reqs;
    @(negedge clk);
    check({tag, ".ready_in"}, 32'(req_ready), 32'd1);
    is_ls = ls; memread = rd; memwrite = wr; mask = m; addr = a; wdata = wd;
    req_valid = 1'b1;
    e.rdata = want_rd;
    e.err   = want_err;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0; is_ls = 1'b0; memread = 1'b0; memwrite = 1'b0;
    mask = 3'b111; addr = 32'hFFFF_FFFF; wdata = 32'h5555_AAAA;
    cyc  = 1;
    reqs = 0;
    while (!resp_valid && cyc < 64) begin
      ram_ack   = 1'b0;
      ram_rdata = 32'h0BAD_F00D;
      if (ram_req) begin
        reqs++;
        if (reqs == 1 || reqs == want_reqs) begin
          check($sformatf("%s.ram_addr@%0d", tag, reqs), 32'(ram_addr), a >> 2);
          check($sformatf("%s.ram_be@%0d", tag, reqs), 32'(ram_be), 32'(want_be));
          check($sformatf("%s.ram_we@%0d", tag, reqs), 32'(ram_we), 32'(wr));
          check($sformatf("%s.ready_busy@%0d", tag, reqs), 32'(req_ready), 32'd0);
          if (wr) check($sformatf("%s.ram_wdata@%0d", tag, reqs), ram_wdata, want_wd);
        end
        if (reqs == ack_cyc) begin
          ram_ack   = 1'b1;
          ram_rdata = word;
        end
      end
      @(negedge clk);
      cyc++;
    end
    ram_ack   = 1'b0;
    ram_rdata = 32'h0BAD_F00D;
    check({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
    if (sb.size() > 0) e = sb.pop_front();
    check({tag, ".resp_rdata"}, resp_rdata, e.rdata);
    check({tag, ".resp_err"}, 32'(resp_err), 32'(e.err));
    check({tag, ".latency"}, 32'(cyc), 32'(want_lat));
    check({tag, ".ram_req_cycles"}, 32'(reqs), 32'(want_reqs));
    @(negedge clk);
    check({tag, ".pulse_end"}, 32'(resp_valid), 32'd0);
    check({tag, ".ready_after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0] lmasks [4];
    logic [31:0] lword;
    logic [3:0]  lbe;
    int          rv_seen;
    lmasks[0] = MASK_LB; lmasks[1] = MASK_LBU; lmasks[2] = MASK_LH; lmasks[3] = MASK_LHU;

    rst_n = 1'b0; req_valid = 1'b0; memread = 1'b0; memwrite = 1'b0; is_ls = 1'b0;
    mask = '0; addr = '0; wdata = '0; ram_ack = 1'b0; ram_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst.req_ready", 32'(req_ready), 32'd1);
    check("rst.ram_req", 32'(ram_req), 32'd0);
    check("rst.ram_we", 32'(ram_we), 32'd0);
    check("rst.ram_be", 32'(ram_be), 32'd0);
    check("rst.ram_addr", 32'(ram_addr), 32'd0);
    check("rst.ram_wdata", ram_wdata, 32'd0);
    check("rst.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.resp_rdata", resp_rdata, 32'd0);
    check("rst.resp_err", 32'(resp_err), 32'd0);
    rst_n = 1'b1;

    // stray ack in IDLE
    @(negedge clk);
    ram_ack = 1'b1; ram_rdata = 32'h1234_5678;
    repeat (2) begin
      @(negedge clk);
      check("stray_ack.resp_valid", 32'(resp_valid), 32'd0);
      check("stray_ack.ram_req", 32'(ram_req), 32'd0);
    end
    ram_ack = 1'b0;

    xact("lw_100", 1, 1, 0, MASK_LW, 32'h100, 32'h0, 2, 32'hDEAD_BEEF,
         4'b1111, 32'h0, 32'hDEAD_BEEF, ERR_OK, 2, 4);
    xact("lb_103", 1, 1, 0, MASK_LB, 32'h103, 32'h0, 1, 32'h8011_2233,
         4'b1000, 32'h0, 32'hFFFF_FF80, ERR_OK, 1, 3);
    xact("lbu_103", 1, 1, 0, MASK_LBU, 32'h103, 32'h0, 1, 32'h8011_2233,
         4'b1000, 32'h0, 32'h0000_0080, ERR_OK, 1, 3);
    xact("sh_102", 1, 0, 1, MASK_LH, 32'h102, 32'h0000_ABCD, 1, 32'h1234_5678,
         4'b1100, 32'hABCD_ABCD, 32'h0, ERR_OK, 1, 3);
    xact("sw_010", 1, 0, 1, MASK_LW, 32'h010, 32'h1122_3344, 3, 32'h1234_5678,
         4'b1111, 32'h1122_3344, 32'h0, ERR_OK, 3, 5);
    xact("lw_101", 1, 1, 0, MASK_LW, 32'h101, 32'h0, 1, 32'h1234_5678,
         4'b0000, 32'h0, 32'h0, ERR_MISALIGN, 0, 1);
    xact("lw_102", 1, 1, 0, MASK_LW, 32'h102, 32'h0, 1, 32'h1234_5678,
         4'b0000, 32'h0, 32'h0, ERR_MISALIGN, 0, 1);
    xact("sh_001", 1, 0, 1, MASK_LH, 32'h001, 32'h0000_ABCD, 1, 32'h1234_5678,
         4'b0000, 32'h0, 32'h0, ERR_MISALIGN, 0, 1);
    xact("lw_timeout", 1, 1, 0, MASK_LW, 32'h200, 32'h0, 0, 32'h0,
         4'b1111, 32'h0, 32'h0, ERR_TIMEOUT, TMO, TMO + 1);
    xact("lw_after_to", 1, 1, 0, MASK_LW, 32'h204, 32'h0, 1, 32'hCAFE_F00D,
         4'b1111, 32'h0, 32'hCAFE_F00D, ERR_OK, 1, 3);
    xact("ack_at_expiry", 1, 1, 0, MASK_LW, 32'h208, 32'h0, TMO, 32'h7777_1111,
         4'b1111, 32'h0, 32'h7777_1111, ERR_OK, TMO, TMO + 2);
    xact("non_ls", 0, 1, 0, MASK_LW, 32'h300, 32'h0, 1, 32'h1234_5678,
         4'b0000, 32'h0, 32'h0, ERR_OK, 0, 1);
    xact("mask_none", 1, 1, 0, MASK_NONE, 32'h304, 32'h0, 1, 32'h1234_5678,
         4'b0000, 32'h0, 32'h0, ERR_OK, 0, 1);

    for (int lane = 0; lane < 4; lane++) begin
      xact($sformatf("sb_lane%0d", lane), 1, 0, 1, MASK_LBU, 32'h440 + 32'(lane),
           32'h1234_56C3, 1, 32'h0, 4'(1 << lane), 32'hC3C3_C3C3, 32'h0, ERR_OK, 1, 3);
    end

    lword = 32'h8F7E_6D5C;
    for (int mi = 0; mi < 4; mi++) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (lmasks[mi][1:0] == SIZE_H && lane[0]) begin
          xact($sformatf("ld_m%0d_l%0d", mi, lane), 1, 1, 0, lmasks[mi], 32'h500 + 32'(lane),
               32'h0, 1, lword, 4'b0000, 32'h0, 32'h0, ERR_MISALIGN, 0, 1);
        end else begin
          if (lmasks[mi][1:0] == SIZE_B) lbe = 4'(1 << lane);
          else lbe = (lane >= 2) ? 4'b1100 : 4'b0011;
          xact($sformatf("ld_m%0d_l%0d", mi, lane), 1, 1, 0, lmasks[mi], 32'h500 + 32'(lane),
               32'h0, 1, lword, lbe, 32'h0, model_load(lmasks[mi], 2'(lane), lword),
               ERR_OK, 1, 3);
        end
      end
    end

    // reset during ACCESS abandons the access with no response
    @(negedge clk);
    check("rstmid.ready_in", 32'(req_ready), 32'd1);
    is_ls = 1'b1; memread = 1'b1; memwrite = 1'b0; mask = MASK_LW; addr = 32'h400;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; is_ls = 1'b0; memread = 1'b0;
    check("rstmid.ram_req", 32'(ram_req), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmid.ram_req_off", 32'(ram_req), 32'd0);
    check("rstmid.ram_be", 32'(ram_be), 32'd0);
    check("rstmid.ram_addr", 32'(ram_addr), 32'd0);
    check("rstmid.req_ready", 32'(req_ready), 32'd1);
    check("rstmid.resp_valid", 32'(resp_valid), 32'd0);
    rst_n = 1'b1;
    rv_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid || ram_req) rv_seen++;
    end
    check("rstmid.no_resp", 32'(rv_seen), 32'd0);

    xact("lw_after_rst", 1, 1, 0, MASK_LW, 32'h404, 32'h0, 1, 32'h0F0F_F0F0,
         4'b1111, 32'h0, 32'h0F0F_F0F0, ERR_OK, 1, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
